// File: rtl/instr_encoder_if.sv
// Field-in / word-out bus of the instruction encoder, plus its reject status.
// The master drives fields and takes encoded words; the slave is the encoder.
interface instr_encoder_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned ERR_W  = 8
);
    logic              InValid;
    logic              InReady;
    logic [3:0]        ClassI;
    logic [2:0]        Fun3I;
    logic [6:0]        Fun7I;
    logic [4:0]        RdI;
    logic [4:0]        Rs1I;
    logic [4:0]        Rs2I;
    logic [31:0]       ImmI;
    logic              AddrLoad;
    logic [ADDR_W-1:0] AddrBase;
    logic              OutValid;
    logic              OutReady;
    logic [31:0]       InstrO;
    logic [ADDR_W-1:0] AddrO;
    logic              ErrValid;
    logic [1:0]        ErrCode;
    logic [ERR_W-1:0]  ErrCount;

    modport master (
        output InValid, ClassI, Fun3I, Fun7I, RdI, Rs1I, Rs2I, ImmI, AddrLoad, AddrBase,
        output OutReady,
        input  InReady, OutValid, InstrO, AddrO, ErrValid, ErrCode, ErrCount
    );

    modport slave (
        input  InValid, ClassI, Fun3I, Fun7I, RdI, Rs1I, Rs2I, ImmI, AddrLoad, AddrBase,
        input  OutReady,
        output InReady, OutValid, InstrO, AddrO, ErrValid, ErrCode, ErrCount
    );
endinterface

// File: rtl/instr_encoder.sv
// Packs instruction fields into RV32I+F words, stamps each with a word-aligned address
// and rejects illegal classes or unencodable immediates, counting the rejects.
module instr_encoder #(
    parameter int unsigned       ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
    parameter int unsigned       ERR_W      = 8
) (
    input logic              clk,
    input logic              reset,
    instr_encoder_if.slave   bus
);

    localparam logic [3:0] ClsLw    = 4'd0;
    localparam logic [3:0] ClsSw    = 4'd1;
    localparam logic [3:0] ClsR     = 4'd2;
    localparam logic [3:0] ClsB     = 4'd3;
    localparam logic [3:0] ClsIAlu  = 4'd4;
    localparam logic [3:0] ClsJal   = 4'd5;
    localparam logic [3:0] ClsAuipc = 4'd6;
    localparam logic [3:0] ClsLui   = 4'd7;
    localparam logic [3:0] ClsJalr  = 4'd8;
    localparam logic [3:0] ClsFlw   = 4'd9;
    localparam logic [3:0] ClsFsw   = 4'd10;
    localparam logic [3:0] ClsFp    = 4'd11;

    typedef enum logic [2:0] {FmtR, FmtI, FmtShift, FmtS, FmtB, FmtU, FmtJ} format_e;

    logic              outValidQ;
    logic [31:0]       instrQ;
    logic [ADDR_W-1:0] addrQ;
    logic [ADDR_W-1:0] nextAddrQ;
    logic              errValidQ;
    logic [1:0]        errCodeQ;
    logic [ERR_W-1:0]  errCountQ;

    format_e           fmt;
    logic [6:0]        opcode;
    logic [2:0]        fun3;
    logic              classOk;
    logic              immOk;
    logic [31:0]       word;
    logic [1:0]        rejectCode;
    logic              accept;
    logic              legal;
    logic [ADDR_W-1:0] baseAligned;
    logic [ADDR_W-1:0] emitAddr;

    logic [31:0] imm;
    logic        fits12;
    logic        fits13;
    logic        fits21;
    logic        isShift;

    assign imm     = bus.ImmI;
    // A signed N-bit value has all bits from N-1 upward equal.
    assign fits12  = (imm[31:11] == '0) || (imm[31:11] == '1);
    assign fits13  = ((imm[31:12] == '0) || (imm[31:12] == '1)) && !imm[0];
    assign fits21  = ((imm[31:20] == '0) || (imm[31:20] == '1)) && !imm[0];
    assign isShift = (bus.ClassI == ClsIAlu) && (bus.Fun3I[1:0] == 2'b01);

    always_comb begin
        fmt     = FmtR;
        opcode  = 7'b0000000;
        fun3    = bus.Fun3I;
        classOk = 1'b1;
        immOk   = 1'b1;
        unique case (bus.ClassI)
            ClsLw:    begin fmt = FmtI; opcode = 7'b0000011; fun3 = 3'b010; immOk = fits12; end
            ClsSw:    begin fmt = FmtS; opcode = 7'b0100011; fun3 = 3'b010; immOk = fits12; end
            ClsR:     begin fmt = FmtR; opcode = 7'b0110011; end
            ClsB:     begin fmt = FmtB; opcode = 7'b1100011; immOk = fits13; end
            ClsIAlu: begin
                opcode = 7'b0010011;
                if (isShift) begin
                    fmt   = FmtShift;
                    immOk = (imm[31:5] == '0);
                end else begin
                    fmt   = FmtI;
                    immOk = fits12;
                end
            end
            ClsJal:   begin fmt = FmtJ; opcode = 7'b1101111; immOk = fits21; end
            ClsAuipc: begin fmt = FmtU; opcode = 7'b0010111; immOk = (imm[11:0] == '0); end
            ClsLui:   begin fmt = FmtU; opcode = 7'b0110111; immOk = (imm[11:0] == '0); end
            ClsJalr:  begin fmt = FmtI; opcode = 7'b1100111; fun3 = 3'b000; immOk = fits12; end
            ClsFlw:   begin fmt = FmtI; opcode = 7'b0000111; fun3 = 3'b010; immOk = fits12; end
            ClsFsw:   begin fmt = FmtS; opcode = 7'b0100111; fun3 = 3'b010; immOk = fits12; end
            ClsFp:    begin fmt = FmtR; opcode = 7'b1010011; end
            default:  classOk = 1'b0;
        endcase
    end

    always_comb begin
        word = '0;
        unique case (fmt)
            FmtR:     word = {bus.Fun7I, bus.Rs2I, bus.Rs1I, fun3, bus.RdI, opcode};
            FmtI:     word = {imm[11:0], bus.Rs1I, fun3, bus.RdI, opcode};
            FmtShift: word = {bus.Fun7I, imm[4:0], bus.Rs1I, fun3, bus.RdI, opcode};
            FmtS:     word = {imm[11:5], bus.Rs2I, bus.Rs1I, fun3, imm[4:0], opcode};
            FmtB:     word = {imm[12], imm[10:5], bus.Rs2I, bus.Rs1I, fun3, imm[4:1], imm[11],
                              opcode};
            FmtU:     word = {imm[31:12], bus.RdI, opcode};
            FmtJ:     word = {imm[20], imm[10:1], imm[11], imm[19:12], bus.RdI, opcode};
            default:  word = '0;
        endcase
    end

    assign rejectCode  = !classOk ? 2'b01 : (!immOk ? 2'b10 : 2'b00);
    assign legal       = classOk && immOk;
    assign accept      = bus.InValid && bus.InReady;
    assign baseAligned = {bus.AddrBase[ADDR_W-1:2], 2'b00};
    assign emitAddr    = bus.AddrLoad ? baseAligned : nextAddrQ;

    always_ff @(posedge clk) begin
        if (reset) begin
            outValidQ <= 1'b0;
            instrQ    <= '0;
            addrQ     <= RESET_ADDR;
            nextAddrQ <= RESET_ADDR;
            errValidQ <= 1'b0;
            errCodeQ  <= 2'b00;
            errCountQ <= '0;
        end else begin
            if (accept && legal) begin
                outValidQ <= 1'b1;
                instrQ    <= word;
                addrQ     <= emitAddr;
                nextAddrQ <= emitAddr + ADDR_W'(4);
            end else begin
                if (bus.OutReady) begin
                    outValidQ <= 1'b0;
                end
                if (bus.AddrLoad) begin
                    nextAddrQ <= baseAligned;
                end
            end
            errValidQ <= accept && !legal;
            if (accept && !legal) begin
                errCodeQ <= rejectCode;
                if (!(&errCountQ)) begin
                    errCountQ <= errCountQ + ERR_W'(1);
                end
            end
        end
    end

    assign bus.InReady  = !outValidQ || bus.OutReady;
    assign bus.OutValid = outValidQ;
    assign bus.InstrO   = instrQ;
    assign bus.AddrO    = addrQ;
    assign bus.ErrValid = errValidQ;
    assign bus.ErrCode  = errCodeQ;
    assign bus.ErrCount = errCountQ;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed encodings plus randomized traffic checked every cycle
// against a field-level reference model of words, addresses and reject status.
module tb_instr_encoder;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instr_encoder_if #(.ADDR_W(32), .ERR_W(8)) bus ();

    instr_encoder #(.ADDR_W(32), .RESET_ADDR(32'h0), .ERR_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic        mValid;
    logic [31:0] mInstr;
    logic [31:0] mAddr;
    logic [31:0] mNext;
    logic        mErrValid;
    logic [1:0]  mErrCode;
    int          mErrCount;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Reference: builds the word by shifting spec fields into place; code 1 = bad class, 2 = bad imm.
    function automatic void refEncode(input logic [3:0] c, input logic [2:0] f3,
                                      input logic [6:0] f7, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic [31:0] imm, output logic [31:0] w,
                                      output logic [1:0] code);
        int s;
        bit ok, in12;
        logic [31:0] r1, r2, rdf, fn3, fn7, i12, sf, bf, jf, uf;
        s   = $signed(imm);
        r1  = 32'(rs1) << 15;
        r2  = 32'(rs2) << 20;
        rdf = 32'(rd) << 7;
        fn3 = 32'(f3) << 12;
        fn7 = 32'(f7) << 25;
        i12 = (imm & 32'hFFF) << 20;
        sf  = (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
        bf  = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25)
            | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 1) << 7);
        jf  = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
            | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12);
        uf  = imm & 32'hFFFFF000;
        in12 = (s >= -2048) && (s <= 2047);
        ok   = 1'b1;
        w    = '0;
        code = 2'd0;
        case (c)
            4'd0:  begin w = i12 | r1 | 32'h2000 | rdf | 32'h03; ok = in12; end
            4'd1:  begin w = sf | r2 | r1 | 32'h2000 | 32'h23; ok = in12; end
            4'd2:  w = fn7 | r2 | r1 | fn3 | rdf | 32'h33;
            4'd3:  begin
                w  = bf | r2 | r1 | fn3 | 32'h63;
                ok = (s >= -4096) && (s <= 4095) && (imm % 2 == 0);
            end
            4'd4:  begin
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    w  = fn7 | ((imm & 32'h1F) << 20) | r1 | fn3 | rdf | 32'h13;
                    ok = imm < 32;
                end else begin
                    w  = i12 | r1 | fn3 | rdf | 32'h13;
                    ok = in12;
                end
            end
            4'd5:  begin
                w  = jf | rdf | 32'h6F;
                ok = (s >= -(1 << 20)) && (s < (1 << 20)) && (imm % 2 == 0);
            end
            4'd6:  begin w = uf | rdf | 32'h17; ok = (imm % 4096 == 0); end
            4'd7:  begin w = uf | rdf | 32'h37; ok = (imm % 4096 == 0); end
            4'd8:  begin w = i12 | r1 | rdf | 32'h67; ok = in12; end
            4'd9:  begin w = i12 | r1 | 32'h2000 | rdf | 32'h07; ok = in12; end
            4'd10: begin w = sf | r2 | r1 | 32'h2000 | 32'h27; ok = in12; end
            4'd11: w = fn7 | r2 | r1 | fn3 | rdf | 32'h53;
            default: code = 2'd1;
        endcase
        if (code == 2'd0 && !ok) code = 2'd2;
    endfunction

    task automatic modelReset();
        mValid = 0; mInstr = 0; mAddr = 0; mNext = 0;
        mErrValid = 0; mErrCode = 0; mErrCount = 0;
    endtask

    task automatic drive(input logic v, input logic [3:0] c, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] imm);
        bus.InValid = v; bus.ClassI = c; bus.Fun3I = f3; bus.Fun7I = f7;
        bus.RdI = rd; bus.Rs1I = rs1; bus.Rs2I = rs2; bus.ImmI = imm;
    endtask

    // One clock: check InReady, advance the model from the sampled inputs, check outputs.
    task automatic cycle();
        logic acc, rst, ordy, ld;
        logic [31:0] w, ea, base;
        logic [1:0]  code;
        #1;
        chk("InReady", 32'(bus.InReady), 32'(!mValid || bus.OutReady));
        acc  = bus.InValid && (!mValid || bus.OutReady);
        rst  = reset;
        ordy = bus.OutReady;
        ld   = bus.AddrLoad;
        base = bus.AddrBase & ~32'h3;
        refEncode(bus.ClassI, bus.Fun3I, bus.Fun7I, bus.RdI, bus.Rs1I, bus.Rs2I, bus.ImmI,
                  w, code);
        ea = ld ? base : mNext;
        @(posedge clk);
        #1;
        if (rst) begin
            modelReset();
        end else begin
            mErrValid = acc && (code != 0);
            if (acc && code != 0) begin
                mErrCode = code;
                if (mErrCount < 255) mErrCount++;
            end
            if (acc && code == 0) begin
                mValid = 1; mInstr = w; mAddr = ea; mNext = ea + 32'd4;
            end else begin
                if (ordy) mValid = 0;
                if (ld) mNext = base;
            end
        end
        chk("OutValid", 32'(bus.OutValid), 32'(mValid));
        if (mValid) begin
            chk("InstrO", bus.InstrO, mInstr);
            chk("AddrO", bus.AddrO, mAddr);
        end
        chk("ErrValid", 32'(bus.ErrValid), 32'(mErrValid));
        chk("ErrCode", 32'(bus.ErrCode), 32'(mErrCode));
        chk("ErrCount", 32'(bus.ErrCount), 32'(mErrCount));
    endtask

    initial begin
        logic [31:0] imm;
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        bus.OutReady = 1'b1;
        bus.AddrLoad = 1'b0;
        bus.AddrBase = '0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst OutValid", 32'(bus.OutValid), 32'h0);
        chk("rst InstrO", bus.InstrO, 32'h0);
        chk("rst AddrO", bus.AddrO, 32'h0);
        chk("rst ErrValid", 32'(bus.ErrValid), 32'h0);
        chk("rst ErrCode", 32'(bus.ErrCode), 32'h0);
        chk("rst ErrCount", 32'(bus.ErrCount), 32'h0);
        reset = 1'b0;

        // addi x1,x0,5
        drive(1, 4, 0, 0, 1, 0, 0, 5); cycle();
        chk("addi word", bus.InstrO, 32'h00500093);
        chk("addi addr", bus.AddrO, 32'h0);

        // lw / add / sub back-to-back
        drive(1, 0, 0, 0, 2, 1, 0, 8); cycle();
        chk("lw word", bus.InstrO, 32'h0080A103);
        chk("lw addr", bus.AddrO, 32'h4);
        drive(1, 2, 0, 7'h00, 3, 1, 2, 0); cycle();
        chk("add word", bus.InstrO, 32'h002081B3);
        chk("add addr", bus.AddrO, 32'h8);
        drive(1, 2, 0, 7'h20, 3, 1, 2, 0); cycle();
        chk("sub word", bus.InstrO, 32'h402081B3);
        chk("sub addr", bus.AddrO, 32'hC);

        // beq / jal / lui
        drive(1, 3, 0, 0, 0, 1, 2, 32'hFFFFFFFC); cycle();
        chk("beq word", bus.InstrO, 32'hFE208EE3);
        drive(1, 5, 0, 0, 1, 0, 0, 8); cycle();
        chk("jal word", bus.InstrO, 32'h008000EF);
        drive(1, 7, 0, 0, 5, 0, 0, 32'h12345000); cycle();
        chk("lui word", bus.InstrO, 32'h123452B7);

        // Backpressure: word held, new input waits
        bus.OutReady = 1'b0;
        drive(1, 4, 0, 0, 7, 7, 0, 32'hFFFFFFFF);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("stall InReady", 32'(bus.InReady), 32'h0);
            chk("stall InstrO", bus.InstrO, 32'h123452B7);
            chk("stall AddrO", bus.AddrO, 32'h18);
        end
        bus.OutReady = 1'b1;
        cycle();
        chk("release word", bus.InstrO, 32'hFFF38393);
        chk("release addr", bus.AddrO, 32'h1C);
        drive(0, 0, 0, 0, 0, 0, 0, 0); cycle();

        // Rejects, then the next legal word keeps the address sequence
        drive(1, 13, 0, 0, 1, 1, 1, 0); cycle();
        chk("bad class code", 32'(bus.ErrCode), 32'h1);
        chk("bad class pulse", 32'(bus.ErrValid), 32'h1);
        drive(1, 4, 0, 0, 1, 0, 0, 32'd4096); cycle();
        chk("bad imm code", 32'(bus.ErrCode), 32'h2);
        chk("err count 2", 32'(bus.ErrCount), 32'h2);
        drive(1, 4, 0, 0, 1, 0, 0, 1); cycle();
        chk("post-reject addr", bus.AddrO, 32'h20);
        chk("post-reject pulse", 32'(bus.ErrValid), 32'h0);
        drive(1, 14, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 300; i++) cycle();
        chk("err count sat", 32'(bus.ErrCount), 32'd255);

        // Address reload and wrap
        bus.AddrLoad = 1'b1; bus.AddrBase = 32'h103;
        drive(1, 4, 0, 0, 1, 0, 0, 1); cycle();
        chk("load addr", bus.AddrO, 32'h100);
        bus.AddrLoad = 1'b0; cycle();
        chk("load next", bus.AddrO, 32'h104);
        bus.AddrLoad = 1'b1; bus.AddrBase = 32'hFFFFFFFC; cycle();
        chk("top addr", bus.AddrO, 32'hFFFFFFFC);
        bus.AddrLoad = 1'b0; cycle();
        chk("wrap addr", bus.AddrO, 32'h0);

        // Reset discards a pending word
        bus.OutReady = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1; cycle();
        chk("reset drop", 32'(bus.OutValid), 32'h0);
        reset = 1'b0; bus.OutReady = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 3))
                0: imm = $urandom;
                1: imm = 32'($signed($urandom_range(0, 8192)) - 4096);
                2: imm = $urandom_range(0, 40);
                default: imm = 32'($signed($urandom_range(0, 32'h200000)) - 32'sh100000);
            endcase
            drive($urandom_range(0, 9) < 8, 4'($urandom_range(0, 15)), 3'($urandom),
                  7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), imm);
            bus.OutReady = $urandom_range(0, 3) != 0;
            bus.AddrLoad = $urandom_range(0, 19) == 0;
            bus.AddrBase = $urandom;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
